// File: rtl/sha3_pkg.sv
// Shared constants and FSM encoding for the SHA-3 squeeze path.
package sha3_pkg;

  localparam int STATE_W     = 1600;
  localparam int RATE_BITS   = 1088;
  localparam int DIGEST_BITS = 256;
  localparam int WORD_W      = 64;
  localparam int RATE_OFFSET = STATE_W - RATE_BITS;

  typedef enum logic {
    SQ_IDLE = 1'b0,
    SQ_EMIT = 1'b1
  } squeeze_state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sha3_word_select.sv
// Counter-indexed digest word mux; byte-reverses each word when
// SHA3_SQUEEZE_BYTESWAP_EN is defined (FIPS 202 lane byte order).
module sha3_word_select #(
  parameter int DIGEST_BITS = 256,
  parameter int WORD_W      = 64,
  parameter int CNT_W       = 2
) (
  input  logic [DIGEST_BITS-1:0] snap,
  input  logic [CNT_W-1:0]       idx,
  output logic [WORD_W-1:0]      word
);

  localparam int NWORDS = DIGEST_BITS / WORD_W;
  localparam int NBYTES = WORD_W / 8;

  logic [WORD_W-1:0] word_raw;

  // Word 0 sits at the most significant end of the snapshot.
  always_comb begin
    word_raw = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (idx == CNT_W'(i)) word_raw = snap[DIGEST_BITS-1-i*WORD_W -: WORD_W];
    end
  end

`ifdef SHA3_SQUEEZE_BYTESWAP_EN
  always_comb begin
    word = '0;
    for (int b = 0; b < NBYTES; b++) begin
      word[b*8 +: 8] = word_raw[(NBYTES-1-b)*8 +: 8];
    end
  end
`else
  assign word = word_raw;
`endif

endmodule

// File: rtl/sha3_squeeze_stage.sv
// Snapshots the digest from the final Keccak state and streams it out as
// WORD_W-bit words over valid/ready. Optional macro: SHA3_SQUEEZE_BYTESWAP_EN.
module sha3_squeeze_stage #(
  parameter int DIGEST_BITS = sha3_pkg::DIGEST_BITS,
  parameter int WORD_W      = sha3_pkg::WORD_W,
  parameter int RATE_BITS   = sha3_pkg::RATE_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [sha3_pkg::STATE_W-1:0] state_in,
  input  logic                       state_valid,
  output logic                       state_ready,
  output logic [WORD_W-1:0]          out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy
);
  import sha3_pkg::*;

  localparam int NWORDS   = DIGEST_BITS / WORD_W;
  localparam int CNT_W    = cnt_width(NWORDS);
  localparam int RATE_LSB = STATE_W - RATE_BITS;
  localparam int RATE_MSB = RATE_LSB + RATE_BITS - 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NWORDS - 1);

  squeeze_state_e         fsm;
  logic [CNT_W-1:0]       cnt;
  logic [DIGEST_BITS-1:0] snap;
  logic                   valid_q;
  logic                   last_q;
  logic                   busy_q;
  logic                   accept;
  logic                   unused_state;

  assign unused_state = ^state_in[RATE_MSB-DIGEST_BITS:0];

  // Ready also on the final beat being taken, so digests run back-to-back.
  assign state_ready = !valid_q || (last_q && out_ready);
  assign accept      = state_valid && state_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm     <= SQ_IDLE;
      cnt     <= '0;
      snap    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (accept) begin
        fsm     <= SQ_EMIT;
        snap    <= state_in[RATE_MSB -: DIGEST_BITS];
        cnt     <= '0;
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
        last_q  <= (NWORDS == 1);
      end else begin
        case (fsm)
          SQ_IDLE: ;
          SQ_EMIT: begin
            if (out_ready) begin
              if (last_q) begin
                fsm     <= SQ_IDLE;
                cnt     <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                last_q  <= 1'b0;
              end else begin
                cnt    <= cnt + 1'b1;
                last_q <= ((cnt + 1'b1) == LAST_IDX);
              end
            end
          end
          default: fsm <= SQ_IDLE;
        endcase
      end
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;

  sha3_word_select #(
    .DIGEST_BITS (DIGEST_BITS),
    .WORD_W      (WORD_W),
    .CNT_W       (CNT_W)
  ) u_word_select (
    .snap (snap),
    .idx  (cnt),
    .word (out_data)
  );

endmodule

// File: doc/sha3_squeeze_stage.md
Name: sha3_squeeze_stage

Overview:
- Output end of the Keccak-f[1600] pipeline. The absorb side XORs rate blocks into state[1599:512].
- This block accepts the final permuted state once the round pipeline reports completion.
- It snapshots the digest portion of the rate region and streams it out as WORD_W-bit words over a valid/ready interface.
- It is the only path from the hashing core to the host-side result interface.

Parameters:
- DIGEST_BITS, 256, digest length in bits; multiple of WORD_W, ≤ RATE_BITS.
- WORD_W, 64, output word width (one Keccak lane).
- RATE_BITS, 1088, rate width; rate region is state[1599 -: RATE_BITS].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- state_in  in  1600  permuted state from the round pipeline.
- state_valid  in  1  state_in is final; driven by the rounds-completed flag.
- state_ready  out  1  block can accept a new state.
- out_data  out  WORD_W  current digest word.
- out_valid  out  1  out_data is valid.
- out_last  out  1  current word is the final word of the digest.
- out_ready  in  1  downstream accepts the word.
- busy  out  1  squeeze in progress.

Behaviour:
- Constants:
  - NWORDS = DIGEST_BITS/WORD_W (4 at defaults).
  - Word counter width = clog2(NWORDS), minimum 1.
- Reset (async, rst=1):
  - FSM=IDLE, counter=0, snapshot register=0.
  - out_valid=0, out_last=0, busy=0, out_data=0.
  - state_ready=1 after deassertion.
- FSM states: IDLE and EMIT.
- IDLE:
  - state_ready=1, out_valid=0.
  - On state_valid&state_ready: snap <= state_in[1599 -: DIGEST_BITS], counter <= 0, go to EMIT.
- EMIT:
  - out_valid=1, busy=1, state_ready=0, except in the last-beat case below.
  - out_data = snap[DIGEST_BITS-1-counter*WORD_W -: WORD_W]. Word 0 = state_in[1599:1536].
  - out_last = (counter==NWORDS-1).
- Handshake:
  - A word transfers on out_valid&out_ready.
  - While out_valid&!out_ready, out_data and out_last hold stable, with no glitching of out_valid.
  - Transfer with !out_last: counter += 1.
  - Transfer with out_last: return to IDLE and clear counter.
- Back-to-back: state_ready = IDLE | (EMIT & out_last & out_ready).
  - If state_valid is high in that same cycle, reload the snapshot and stay in EMIT with counter=0.
  - No bubble between digests.
- Latency: first word is valid exactly 1 cycle after the accepting edge. With out_ready held high, a digest takes NWORDS cycles.
- state_valid while busy (not last beat): ignored, not captured. The upstream must hold the state until state_ready.
- Mid-operation reset: the squeeze aborts immediately, out_valid drops asynchronously, and any partial digest is discarded.
- out_data is registered or driven from a registered snapshot through a mux on counter. There is no combinational path from state_in to out_data.
- Bits of state_in outside the digest field are unused.

Optional Feature:
- Macro: SHA3_SQUEEZE_BYTESWAP_EN.
- Defined:
  - Each WORD_W word is byte-reversed before out_data (byte 0 ↔ byte WORD_W/8-1), giving the FIPS 202 little-endian lane byte order.
  - out_last and timing are unchanged.
- Undefined: words are emitted in raw state bit order.

Decomposition:
- Shared package sha3_pkg:
  - STATE_W=1600, RATE_BITS=1088, DIGEST_BITS=256, WORD_W=64.
  - Rate offset 512.
  - FSM state encoding: IDLE=1'b0, EMIT=1'b1.
- One sub-module: sha3_word_select.
  - Combinational.
  - Counter-indexed word mux plus the optional byteswap.
  - Reused later by any wider-output variant.

Test Plan:
- Reset then a single digest:
  - Stimulus: state_in[1599:1344] = {64'h1111..., 64'h2222..., 64'h3333..., 64'h4444...} with state_valid for 1 cycle; out_ready=1.
  - Required: words 1111.., 2222.., 3333.., 4444.. on 4 consecutive cycles starting 1 cycle after accept; out_last only on 4444..; state_ready back to 1 afterwards.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles on word 1.
  - Required: out_data=2222.. held stable with out_valid=1; the counter does not advance; the digest completes correctly once out_ready rises.
- Back-to-back:
  - Stimulus: second state (words AAAA.., BBBB.., CCCC.., DDDD..) with state_valid asserted on the last-beat cycle of the first digest.
  - Required: accepted that cycle; AAAA.. appears the next cycle with no bubble.
- Ignored input:
  - Stimulus: state_valid pulsed during word 1 with a different state.
  - Required: state_ready=0 that cycle; the current digest is unchanged.
- Async reset mid-squeeze:
  - Stimulus: rst asserted between clock edges during word 2.
  - Required: out_valid=0 and busy=0 immediately; after release, state_ready=1 and a new digest starts from word 0.
- SHA3_SQUEEZE_BYTESWAP_EN defined:
  - Stimulus: word 0 = 64'h0011223344556677.
  - Required: out_data = 64'h7766554433221100.
